// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO.
//   FIFO_MODE_STD / FIFO_MODE_FWFT : values of the FWFT parameter
//   clog2()                        : ceiling log2, sizes the occupancy counter
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Bits needed to encode values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle of the single-clock FIFO.
//   master : the user side (drives write_en, read_en, wdata_i)
//   slave  : the FIFO side (drives data out, status and error flags)
interface sync_fifo_param_if #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 8
);
    logic                  write_en;
    logic                  read_en;
    logic [DATA_LEN-1:0]   wdata_i;
    logic [DATA_LEN-1:0]   rdata_o;
    logic                  rempty_o;
    logic                  wfull_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic [ADDR_LEN:0]     count_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output write_en, read_en, wdata_i,
        input  rdata_o, rempty_o, wfull_o, almost_full_o, almost_empty_o,
               count_o, overflow_o, underflow_o
    );

    modport slave (
        input  write_en, read_en, wdata_i,
        output rdata_o, rempty_o, wfull_o, almost_full_o, almost_empty_o,
               count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: synchronous write port, asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : combinational read data
// Contents are not reset.
module fifo_dpram #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_LEN-1:0] waddr,
    input  logic [DATA_LEN-1:0] wdata,
    input  logic [ADDR_LEN-1:0] raddr,
    output logic [DATA_LEN-1:0] rdata
);
    logic [DATA_LEN-1:0] mem [2**ADDR_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds, standard or first-word-fall-through read, and sticky
// overflow/underflow flags.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sync_fifo_param_if.slave (write_en, read_en, wdata_i in;
//         rdata_o, rempty_o, wfull_o, almost_full_o, almost_empty_o,
//         count_o, overflow_o, underflow_o out)
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 8,
    parameter int FWFT     = FIFO_MODE_STD,
    parameter int AF_LEVEL = 2**ADDR_LEN - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);
    localparam int DEPTH   = 2**ADDR_LEN;
    localparam int COUNT_W = clog2(DEPTH + 1);

    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] AF_C    = COUNT_W'(AF_LEVEL);
    localparam logic [COUNT_W-1:0] AE_C    = COUNT_W'(AE_LEVEL);

    logic [ADDR_LEN-1:0] wptr_reg;
    logic [ADDR_LEN-1:0] rptr_reg;
    logic [COUNT_W-1:0]  count_reg;
    logic [COUNT_W-1:0]  count_next;
    logic                empty_reg;
    logic                full_reg;
    logic                af_reg;
    logic                ae_reg;
    logic                ovf_reg;
    logic                unf_reg;
    logic                wr_acc;
    logic                rd_acc;
    logic [DATA_LEN-1:0] rd_word;

    // A write into a full FIFO is still accepted when a read frees a slot
    // on the same edge; it lands in the slot being vacated.
    always_comb begin
        rd_acc     = bus.read_en & ~empty_reg;
        wr_acc     = bus.write_en & (~full_reg | rd_acc);
        count_next = count_reg + COUNT_W'(wr_acc) - COUNT_W'(rd_acc);
    end

    // Flags are computed from count_next so they move together with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
            af_reg    <= 1'b0;
            ae_reg    <= 1'b1;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_reg <= wptr_reg + ADDR_LEN'(1);
            end
            if (rd_acc) begin
                rptr_reg <= rptr_reg + ADDR_LEN'(1);
            end
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == DEPTH_C);
            af_reg    <= (count_next >= AF_C);
            ae_reg    <= (count_next <= AE_C);
            if (bus.write_en & full_reg & ~rd_acc) begin
                ovf_reg <= 1'b1;
            end
            if (bus.read_en & empty_reg) begin
                unf_reg <= 1'b1;
            end
        end
    end

    fifo_dpram #(
        .DATA_LEN (DATA_LEN),
        .ADDR_LEN (ADDR_LEN)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_reg),
        .wdata (bus.wdata_i),
        .raddr (rptr_reg),
        .rdata (rd_word)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head of queue shown directly; forced to zero while empty so
            // stale memory never leaks out.
            assign bus.rdata_o = empty_reg ? '0 : rd_word;
        end else begin : g_std
            logic [DATA_LEN-1:0] rdata_reg;

            // Captures the head word on an accepted read, holds otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (rd_acc) begin
                    rdata_reg <= rd_word;
                end
            end

            assign bus.rdata_o = rdata_reg;
        end
    endgenerate

    assign bus.rempty_o       = empty_reg;
    assign bus.wfull_o        = full_reg;
    assign bus.almost_full_o  = af_reg;
    assign bus.almost_empty_o = ae_reg;
    assign bus.count_o        = count_reg;
    assign bus.overflow_o     = ovf_reg;
    assign bus.underflow_o    = unf_reg;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-mode and one FWFT-mode
// instance (DATA_LEN=8, ADDR_LEN=4, AF_LEVEL=14, AE_LEVEL=2), each checked
// against a queue model of the stored words and the expected flags.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst_s = 1'b1;
    logic rst_f = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_LEN(8), .ADDR_LEN(4)) s ();
    sync_fifo_param_if #(.DATA_LEN(8), .ADDR_LEN(4)) f ();

    sync_fifo_param #(
        .DATA_LEN(8), .ADDR_LEN(4), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)
    ) u_std (
        .clk (clk),
        .rst (rst_s),
        .bus (s)
    );

    sync_fifo_param #(
        .DATA_LEN(8), .ADDR_LEN(4), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)
    ) u_fwft (
        .clk (clk),
        .rst (rst_f),
        .bus (f)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboards: words expected to be stored, oldest first.
    logic [7:0] sq [$];
    logic [7:0] fq [$];
    logic [7:0] exp_rd_s = 8'h00;
    logic       exp_ovf_s = 1'b0;
    logic       exp_unf_s = 1'b0;
    logic       exp_ovf_f = 1'b0;
    logic       exp_unf_f = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic std_status(input string ph);
        chk({ph, ":count"},  32'(s.count_o),        32'(sq.size()));
        chk({ph, ":empty"},  32'(s.rempty_o),       32'(sq.size() == 0));
        chk({ph, ":full"},   32'(s.wfull_o),        32'(sq.size() == 16));
        chk({ph, ":afull"},  32'(s.almost_full_o),  32'(sq.size() >= 14));
        chk({ph, ":aempty"}, 32'(s.almost_empty_o), 32'(sq.size() <= 2));
        chk({ph, ":ovf"},    32'(s.overflow_o),     32'(exp_ovf_s));
        chk({ph, ":unf"},    32'(s.underflow_o),    32'(exp_unf_s));
        chk({ph, ":rdata"},  32'(s.rdata_o),        32'(exp_rd_s));
    endtask

    task automatic fwft_status(input string ph);
        logic [7:0] head;
        head = (fq.size() != 0) ? fq[0] : 8'h00;
        chk({ph, ":count"},  32'(f.count_o),     32'(fq.size()));
        chk({ph, ":empty"},  32'(f.rempty_o),    32'(fq.size() == 0));
        chk({ph, ":ovf"},    32'(f.overflow_o),  32'(exp_ovf_f));
        chk({ph, ":unf"},    32'(f.underflow_o), 32'(exp_unf_f));
        chk({ph, ":rdata"},  32'(f.rdata_o),     32'(head));
    endtask

    // One clock of stimulus on the standard FIFO, then check after the edge.
    task automatic std_cycle(input string ph, input logic we, input logic re, input logic [7:0] d);
        logic rd;
        logic wr;
        s.write_en = we;
        s.read_en  = re;
        s.wdata_i  = d;
        rd = re && (sq.size() != 0);
        wr = we && ((sq.size() != 16) || rd);
        if (we && (sq.size() == 16) && !rd) exp_ovf_s = 1'b1;
        if (re && (sq.size() == 0)) exp_unf_s = 1'b1;
        if (rd) exp_rd_s = sq.pop_front();
        if (wr) sq.push_back(d);
        @(posedge clk);
        #1;
        s.write_en = 1'b0;
        s.read_en  = 1'b0;
        $display("std  %-6s we=%0b re=%0b d=%02h -> rdata=%02h count=%0d", ph, we, re, d, s.rdata_o, s.count_o);
        std_status(ph);
    endtask

    task automatic fwft_cycle(input string ph, input logic we, input logic re, input logic [7:0] d);
        logic rd;
        logic wr;
        f.write_en = we;
        f.read_en  = re;
        f.wdata_i  = d;
        rd = re && (fq.size() != 0);
        wr = we && ((fq.size() != 16) || rd);
        if (we && (fq.size() == 16) && !rd) exp_ovf_f = 1'b1;
        if (re && (fq.size() == 0)) exp_unf_f = 1'b1;
        if (rd) void'(fq.pop_front());
        if (wr) fq.push_back(d);
        @(posedge clk);
        #1;
        f.write_en = 1'b0;
        f.read_en  = 1'b0;
        $display("fwft %-6s we=%0b re=%0b d=%02h -> rdata=%02h count=%0d", ph, we, re, d, f.rdata_o, f.count_o);
        fwft_status(ph);
    endtask

    task automatic std_reset(input string ph);
        rst_s = 1'b1;
        @(posedge clk);
        #1;
        sq.delete();
        exp_rd_s  = 8'h00;
        exp_ovf_s = 1'b0;
        exp_unf_s = 1'b0;
        $display("std  %-6s reset -> rdata=%02h count=%0d", ph, s.rdata_o, s.count_o);
        std_status(ph);
        rst_s = 1'b0;
    endtask

    initial begin
        int wv;
        s.write_en = 1'b0; s.read_en = 1'b0; s.wdata_i = 8'h00;
        f.write_en = 1'b0; f.read_en = 1'b0; f.wdata_i = 8'h00;

        // Reset state of both instances.
        @(posedge clk);
        @(posedge clk);
        #1;
        std_status("rst");
        fwft_status("rstf");
        rst_s = 1'b0;
        rst_f = 1'b0;
        std_cycle("idle", 1'b0, 1'b0, 8'h00);

        // 1. Fill then drain.
        for (int i = 0; i < 16; i++) std_cycle("fill", 1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 16; i++) std_cycle("drain", 1'b0, 1'b1, 8'h00);

        // 2. Overflow, then simultaneous write+read while full.
        for (int i = 0; i < 16; i++) std_cycle("fill2", 1'b1, 1'b0, 8'(i));
        std_cycle("ovf", 1'b1, 1'b0, 8'hAA);
        std_cycle("fullrw", 1'b1, 1'b1, 8'h55);
        for (int i = 0; i < 16; i++) std_cycle("drain2", 1'b0, 1'b1, 8'h00);
        chk("last_word_55", 32'(s.rdata_o), 32'h55);

        // 3. Underflow, then simultaneous write+read while empty.
        std_cycle("unf", 1'b0, 1'b1, 8'h00);
        std_cycle("emptrw", 1'b1, 1'b1, 8'h33);
        std_cycle("rd33", 1'b0, 1'b1, 8'h00);
        chk("word_33", 32'(s.rdata_o), 32'h33);

        // 4. FWFT instance.
        fwft_cycle("w42", 1'b1, 1'b0, 8'h42);
        chk("fwft_42", 32'(f.rdata_o), 32'h42);
        fwft_cycle("w43", 1'b1, 1'b0, 8'h43);
        fwft_cycle("pop", 1'b0, 1'b1, 8'h00);
        chk("fwft_43", 32'(f.rdata_o), 32'h43);
        fwft_cycle("pop2", 1'b0, 1'b1, 8'h00);
        fwft_cycle("unff", 1'b0, 1'b1, 8'h00);

        // 5. Pointer wrap at occupancy 5..9, clean flags.
        std_reset("rst5");
        for (int i = 0; i < 5; i++) std_cycle("pre", 1'b1, 1'b0, 8'(i));
        wv = 5;
        while (wv < 40) begin
            for (int k = 0; k < 4; k++) begin
                if (wv < 40) begin
                    std_cycle("wrapw", 1'b1, 1'b0, 8'(wv));
                    wv++;
                end
            end
            for (int k = 0; k < 4; k++) std_cycle("wrapr", 1'b0, 1'b1, 8'h00);
        end
        while (sq.size() != 0) std_cycle("wrapd", 1'b0, 1'b1, 8'h00);
        chk("wrap_last", 32'(s.rdata_o), 32'd39);

        // 6. Reset mid-operation at count 7 with overflow set.
        for (int i = 0; i < 16; i++) std_cycle("fill6", 1'b1, 1'b0, 8'(i + 8'h60));
        std_cycle("ovf6", 1'b1, 1'b0, 8'hEE);
        for (int i = 0; i < 9; i++) std_cycle("rd6", 1'b0, 1'b1, 8'h00);
        chk("pre_rst_count", 32'(s.count_o), 32'd7);
        chk("pre_rst_ovf", 32'(s.overflow_o), 32'd1);
        std_reset("rst6");
        std_cycle("w99", 1'b1, 1'b0, 8'h99);
        std_cycle("r99", 1'b0, 1'b1, 8'h00);
        chk("word_99", 32'(s.rdata_o), 32'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
